// File: rtl/ins_loader_pkg.sv
// ins_loader_pkg: loader state encodings, memory depth and text base address
package ins_loader_pkg;
  localparam logic [31:0] TEXT_BASE = 32'h0000_3000;
  localparam int INS_MEM_DEPTH = 1024;
  typedef enum logic [2:0] {LDR_IDLE, LDR_RECV, LDR_WRITE, LDR_CHK, LDR_DONE} ldr_state_t;
endpackage

// File: rtl/ins_loader_if.sv
// ins_loader_if: byte stream in, instruction memory write port and status out
interface ins_loader_if #(parameter int LEN_W = 11);
    logic             start;
    logic [LEN_W-1:0] load_len;
    logic             byte_valid;
    logic [7:0]       byte_data;
    logic             byte_ready;
    logic             we;
    logic [31:0]      waddr;
    logic [31:0]      wdata;
    logic             busy;
    logic             done;
    logic             err;
    modport master(output start, load_len, byte_valid, byte_data,
                   input byte_ready, we, waddr, wdata, busy, done, err);
    modport slave(input start, load_len, byte_valid, byte_data,
                  output byte_ready, we, waddr, wdata, busy, done, err);
endinterface

// File: rtl/ins_word_packer.sv
// ins_word_packer: shifts bytes big-endian into a 32-bit word, flags the 4th byte
module ins_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        shift,
    input  logic [7:0]  byte_in,
    output logic        word_full,
    output logic [31:0] word
);
    logic [1:0] cnt;

    assign word_full = shift && cnt == 2'd3;

    // byte counter wraps after the 4th byte, so no explicit reset between words
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            word <= '0;
        end else if (clear) begin
            cnt  <= '0;
            word <= '0;
        end else if (shift) begin
            cnt  <= cnt + 2'd1;
            word <= {word[23:0], byte_in};
        end
    end
endmodule

// File: rtl/ins_loader.sv
// ins_loader: packs a byte stream into words and writes them to instruction memory; INS_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte
module ins_loader
    import ins_loader_pkg::*;
#(
    parameter int          DEPTH     = INS_MEM_DEPTH,
    parameter logic [31:0] BASE_ADDR = TEXT_BASE,
    parameter int          LEN_W     = 11
) (
    input logic         clk,
    input logic         rst,
    ins_loader_if.slave bus
);
`ifdef INS_LOADER_CHECKSUM_EN
    localparam ldr_state_t AFTER_LAST = LDR_CHK;
    logic [7:0] csum;
`else
    localparam ldr_state_t AFTER_LAST = LDR_DONE;
`endif

    ldr_state_t       state, next;
    logic [LEN_W-1:0] len, word_idx;
    logic             done_q, err_q;
    logic             xfer, accept, zero_len, bad_len, last, word_full;
    logic [31:0]      word;

    assign xfer     = bus.byte_valid && bus.byte_ready;
    assign accept   = bus.start && (state == LDR_IDLE || state == LDR_DONE);
    assign zero_len = bus.load_len == '0;
    assign bad_len  = bus.load_len > LEN_W'(DEPTH);
    assign last     = word_idx + LEN_W'(1) == len;

    assign bus.busy  = state == LDR_RECV || state == LDR_WRITE;
    assign bus.done  = done_q;
    assign bus.err   = err_q;
    assign bus.wdata = word;
    assign bus.waddr = BASE_ADDR + (32'(word_idx) << 2);

    ins_word_packer u_packer (
        .clk      (clk),
        .rst      (rst),
        .clear    (accept),
        .shift    (xfer && state == LDR_RECV),
        .byte_in  (bus.byte_data),
        .word_full(word_full),
        .word     (word)
    );

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= LDR_IDLE;
        else     state <= next;
    end

    // next state and handshake/strobe outputs
    always_comb begin
        next           = state;
        bus.byte_ready = 1'b0;
        bus.we         = 1'b0;
        case (state)
            LDR_IDLE, LDR_DONE: if (bus.start) next = (zero_len || bad_len) ? LDR_DONE : LDR_RECV;
            LDR_RECV: begin
                bus.byte_ready = 1'b1;
                if (word_full) next = LDR_WRITE;
            end
            LDR_WRITE: begin
                bus.we = 1'b1;
                next   = last ? AFTER_LAST : LDR_RECV;
            end
`ifdef INS_LOADER_CHECKSUM_EN
            LDR_CHK: begin
                bus.byte_ready = 1'b1;
                if (bus.byte_valid) next = LDR_DONE;
            end
`endif
            default: next = LDR_IDLE;
        endcase
    end

    // length latch, word index and sticky done/err flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len      <= '0;
            word_idx <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else if (accept) begin
            len      <= bus.load_len;
            word_idx <= '0;
            done_q   <= zero_len || bad_len;
            err_q    <= bad_len;
        end else if (state == LDR_WRITE && !last) begin
            word_idx <= word_idx + LEN_W'(1);
`ifdef INS_LOADER_CHECKSUM_EN
        end else if (state == LDR_CHK && bus.byte_valid) begin
            done_q <= 1'b1;
            err_q  <= bus.byte_data != csum;
`else
        end else if (state == LDR_WRITE) begin
            done_q <= 1'b1;
`endif
        end
    end

`ifdef INS_LOADER_CHECKSUM_EN
    // running XOR of every payload byte accepted in RECV
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                           csum <= '0;
        else if (accept)                   csum <= '0;
        else if (xfer && state == LDR_RECV) csum <= csum ^ bus.byte_data;
    end
`endif
endmodule

// File: tb/tb_ins_loader.sv
// tb_ins_loader: directed loads with a write scoreboard checked by a separate monitor
module tb_ins_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    logic [63:0] exp_q[$];
    logic [7:0]  bytes_q[$];
    logic [31:0] exp_addr;

    ins_loader_if #(.LEN_W(11)) bus ();

    ins_loader #(.DEPTH(1024), .BASE_ADDR(32'h0000_3000), .LEN_W(11)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: every write strobe must match the next queued expected write
    always @(negedge clk) begin
        if (bus.we) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_we: got waddr %h wdata %h expected no write", bus.waddr, bus.wdata);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("waddr", bus.waddr, e[63:32]);
                check("wdata", bus.wdata, e[31:0]);
                check("ready_in_write", {31'd0, bus.byte_ready}, 32'd0);
            end
        end
    end

    task automatic expect_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) bytes_q.push_back(w[i*8 +: 8]);
        exp_q.push_back({exp_addr, w});
        exp_addr += 32'd4;
    endtask

    task automatic pulse_start(input logic [10:0] len);
        bus.start    = 1'b1;
        bus.load_len = len;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok = 1'b0;
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            if (bus.byte_ready) begin
                @(posedge clk);
                #1 ok = 1'b1;
            end
        end
        bus.byte_valid = 1'b0;
        if (!ok) check("byte_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clk);
            seen = bus.done;
        end
        check("done", {31'd0, seen}, 32'd1);
    endtask

    // runs one load of bytes_q; poke pulses a stray start after the 2nd byte
    task automatic run_load(input logic [10:0] len, input bit toggle, input bit poke,
                            input bit use_csum, input logic [7:0] csum);
        logic [7:0] x = 8'h00;
        int i = 0;
        exp_addr = 32'h0000_3000;
        pulse_start(len);
        while (bytes_q.size() > 0) begin
            logic [7:0] b;
            b = bytes_q.pop_front();
            x ^= b;
            send_byte(b);
            if (poke && i == 1) pulse_start(11'd5);
            else if (toggle) begin
                @(posedge clk);
                #1;
            end
            i++;
        end
`ifdef INS_LOADER_CHECKSUM_EN
        send_byte(use_csum ? csum : x);
`else
        if (use_csum) x = csum;
`endif
        wait_done();
        check("all_writes_seen", exp_q.size(), 32'd0);
        check("busy_after", {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.load_len   = '0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = '0;
        exp_addr       = 32'h0000_3000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_err", {31'd0, bus.err}, 32'd0);
        check("rst_ready", {31'd0, bus.byte_ready}, 32'd0);
        check("rst_waddr", bus.waddr, 32'h0000_3000);
        check("rst_wdata", bus.wdata, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // two words, byte_valid held high
        exp_addr = 32'h0000_3000;
        expect_word(32'h2008_0005);
        expect_word(32'h3C01_1001);
        run_load(11'd2, 1'b0, 1'b0, 1'b0, 8'h00);
        check("two_word_err", {31'd0, bus.err}, 32'd0);

        // zero length finishes immediately without writes
        pulse_start(11'd0);
        @(negedge clk);
        check("zero_done", {31'd0, bus.done}, 32'd1);
        check("zero_err", {31'd0, bus.err}, 32'd0);
        check("zero_busy", {31'd0, bus.busy}, 32'd0);

        // oversize length rejected, bytes never accepted
        pulse_start(11'd1025);
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'h5A;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check("big_ready", {31'd0, bus.byte_ready}, 32'd0);
        end
        bus.byte_valid = 1'b0;
        check("big_done", {31'd0, bus.done}, 32'd1);
        check("big_err", {31'd0, bus.err}, 32'd1);

        // gapped bytes with a stray start mid-load
        exp_addr = 32'h0000_3000;
        expect_word(32'hAABB_CCDD);
        run_load(11'd1, 1'b1, 1'b1, 1'b0, 8'h00);
        check("gap_err", {31'd0, bus.err}, 32'd0);

        // reset mid-word abandons the partial word
        pulse_start(11'd1);
        send_byte(8'h55);
        send_byte(8'h66);
        rst = 1'b1;
        #1;
        check("mid_rst_we", {31'd0, bus.we}, 32'd0);
        check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        check("mid_rst_ready", {31'd0, bus.byte_ready}, 32'd0);
        check("mid_rst_done", {31'd0, bus.done}, 32'd0);
        check("mid_rst_wdata", bus.wdata, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        exp_addr = 32'h0000_3000;
        expect_word(32'h1122_3344);
        run_load(11'd1, 1'b0, 1'b0, 1'b0, 8'h00);

`ifdef INS_LOADER_CHECKSUM_EN
        // explicit good and bad checksums
        expect_word(32'h0102_0408);
        run_load(11'd1, 1'b0, 1'b0, 1'b1, 8'h0F);
        check("csum_good_err", {31'd0, bus.err}, 32'd0);
        expect_word(32'h0102_0408);
        run_load(11'd1, 1'b0, 1'b0, 1'b1, 8'h0E);
        check("csum_bad_err", {31'd0, bus.err}, 32'd1);
`endif

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ins_loader.md
Name: ins_loader

Overview:
Writer side of the instruction memory. Receives a program as a byte stream over a valid/ready handshake and packs each group of 4 bytes big-endian into one 32-bit word. Issues one write strobe per word into the instruction memory's write port, at consecutive word addresses starting at the text base. Sits between the host/debug byte source and the instruction memory, and is active only while the CPU is held idle.

Parameters:
DEPTH, 1024, number of 32-bit instruction cells; maximum load length in words.
BASE_ADDR, `TEXT_BASE_ADDRESS, byte address of word 0.
LEN_W, 11, width of load_len; must be at least clog2(DEPTH)+1.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  one-cycle pulse; begins a load; sampled only in IDLE or DONE.
load_len  in  LEN_W  number of words to load; latched on accepted start.
byte_valid  in  1  byte_data holds a valid byte.
byte_data  in  8  program byte.
byte_ready  out  1  loader accepts a byte this cycle.
we  out  1  instruction memory write strobe, one cycle per word.
waddr  out  32  byte address of the word being written.
wdata  out  32  packed instruction word.
busy  out  1  high in RECV and WRITE.
done  out  1  load finished; held until next accepted start or reset.
err  out  1  load rejected or failed; held like done.

Behaviour:
- Reset (async): state=IDLE; byte_ready, we, busy, done, err = 0; waddr=BASE_ADDR; wdata=0; byte and word counters = 0. A reset mid-load drops we immediately and abandons the partial word.
- A byte transfer occurs on a rising edge when byte_valid && byte_ready; byte_data is sampled on that edge.
- States:
  - IDLE/DONE: on start:
    - load_len==0 → DONE, done=1, no writes.
    - load_len>DEPTH → DONE, err=1, done=1, no writes.
    - otherwise → RECV; clear done/err/counters; latch length.
  - RECV: byte_ready=1. Each transfer shifts the byte into the pack register: 1st byte → [31:24], 4th byte → [7:0]. On the 4th transfer → WRITE.
  - WRITE: exactly 1 cycle; byte_ready=0, we=1, wdata=packed word, waddr=BASE_ADDR+4*word_idx. Then word_idx increments. If word_idx+1==len → DONE with done=1; else → RECV.
- Latency: we is asserted the cycle after the 4th byte handshake. Peak throughput is 4 bytes per 5 cycles.
- Address arithmetic is 32-bit; word_idx never exceeds DEPTH-1, so there is no wrap.
- start while busy: ignored. Bytes offered in IDLE/DONE/WRITE: not accepted (byte_ready=0).
- start and byte_valid in the same cycle in IDLE: that byte is not accepted; the first accepted byte is in the following cycle.
- busy = (state==RECV || state==WRITE).

Optional Feature:
Macro INS_LOADER_CHECKSUM_EN.
- Defined:
  - After the last word's WRITE, the loader enters CHK with byte_ready=1 and accepts one extra byte.
  - That byte is compared with the XOR of all payload bytes. Mismatch sets err=1.
  - Then → DONE with done=1. Words already written remain in memory.
- Undefined: no CHK state; DONE directly after the last WRITE; err is set only by the oversize length check.

Decomposition:
- Shared define file ctrl_encode_def.v holds:
  - TEXT_BASE_ADDRESS, which is reused, not redefined;
  - new loader state encodings LDR_IDLE, LDR_RECV, LDR_WRITE, LDR_CHK, LDR_DONE;
  - constant INS_MEM_DEPTH = 1024.
- One sub-module, ins_word_packer: 2-bit byte counter plus 32-bit shift register. It has clear and shift inputs and outputs word_full and word. The FSM, counters and address generation stay in ins_loader.

Test Plan:
- BASE_ADDR=32'h0000_3000, load_len=2, bytes 20 08 00 05 3C 01 10 01 with byte_valid held high → we pulses twice:
  - waddr 0x3000, wdata 0x20080005;
  - waddr 0x3004, wdata 0x3C011001;
  - then done=1, busy=0, err=0.
- load_len=0 start → done=1 next cycle, err=0, we never asserted.
- load_len=1025 start → done=1, err=1, no we, byte_ready stays 0.
- byte_valid toggled every other cycle, load_len=1, bytes AA BB CC DD → single we with wdata 0xAABBCCDD; byte_ready low during WRITE; start pulsed mid-load is ignored.
- Assert rst after 2 bytes of word 1 → we=0 and state IDLE immediately. A new load of 1 word, 11 22 33 44, writes 0x11223344 at 0x3000 (no stale bytes).
- With INS_LOADER_CHECKSUM_EN, 1 word 01 02 04 08 plus checksum 0x0F → done=1, err=0. Repeat with checksum 0x0E → done=1, err=1, and the word is still written.
